// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM states.
package data_mem_ctrl_pkg;

  // Encoding of req_size.
  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  // Controller state: clearing the array, or serving requests.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: request checking, byte enables and
// write-data replication on the way in, lane selection and extension on the way out.
module dmem_lane_align
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_BYTES = 256
) (
  // request side
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic        err_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_lane_o,
  // response side
  input  logic [31:0] rd_word_i,
  input  logic [1:0]  rd_off_i,
  input  logic [1:0]  rd_size_i,
  input  logic        rd_unsigned_i,
  output logic [31:0] rd_data_o
);

  size_e       req_sz;
  size_e       rd_sz;
  logic        misaligned;
  logic        illegal;
  logic        out_of_range;
  logic [3:0]  be_raw;
  logic [31:0] rd_shifted;

  assign req_sz = size_e'(size_i);
  assign rd_sz  = size_e'(rd_size_i);

  // Classify the request and place store data on the lanes it addresses.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    misaligned   = 1'b0;
    illegal      = 1'b0;
    be_raw       = 4'b0000;
    wdata_lane_o = wdata_i;
    case (req_sz)
      SZ_BYTE: begin
        be_raw       = 4'b0001 << addr_i[1:0];
        wdata_lane_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        misaligned   = addr_i[0];
        be_raw       = 4'b0011 << addr_i[1:0];
        wdata_lane_o = {2{wdata_i[15:0]}};
      end
      SZ_WORD: begin
        misaligned   = |addr_i[1:0];
        be_raw       = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
    // Aligned accesses never straddle a word and DEPTH_BYTES is a multiple of
    // 4, so checking the first byte covers every addressed byte.
    out_of_range = (addr_i >= 32'(DEPTH_BYTES));
    err_o        = misaligned | illegal | out_of_range;
    be_o         = err_o ? 4'b0000 : be_raw;
  end

  assign rd_shifted = rd_word_i >> {rd_off_i, 3'b000};

  // Pick the addressed lanes of the read word and sign- or zero-extend them.
  always_comb begin
    rd_data_o = 32'h0;
    case (rd_sz)
      SZ_BYTE: rd_data_o = rd_unsigned_i ? {24'h0, rd_shifted[7:0]}
                                         : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: rd_data_o = rd_unsigned_i ? {16'h0, rd_shifted[15:0]}
                                         : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      SZ_WORD: rd_data_o = rd_word_i;
      default: rd_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with byte/half/word access, a one-cycle response,
// a power-up clear sequence and a combinational tap bus onto a window of words.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int NUM_TAPS    = 9,
  parameter int TAP_BASE    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_busy,
  output logic [32*NUM_TAPS-1:0]  taps
);

  localparam int WORDS     = DEPTH_BYTES / 4;
  localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TAP_WORD0 = TAP_BASE / 4;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [31:0]     mem_q [WORDS];

  logic            accept;
  logic            wr_en;
  logic [AW-1:0]   widx;
  logic            req_err;
  logic [3:0]      req_be;
  logic [31:0]     wdata_lane;

  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic            rsp_load_q;
  logic [1:0]      rd_off_q;
  logic [1:0]      rd_size_q;
  logic            rd_unsigned_q;
  logic [31:0]     rd_word_q;
  logic [31:0]     rd_ext;

  assign req_ready = (state_q == ST_RUN) && !reset;
  assign init_busy = (state_q == ST_INIT) || reset;
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_we;
  assign widx      = req_addr[AW+1:2];

  dmem_lane_align #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_lane_align (
    .addr_i        (req_addr),
    .size_i        (req_size),
    .wdata_i       (req_wdata),
    .err_o         (req_err),
    .be_o          (req_be),
    .wdata_lane_o  (wdata_lane),
    .rd_word_i     (rd_word_q),
    .rd_off_i      (rd_off_q),
    .rd_size_i     (rd_size_q),
    .rd_unsigned_i (rd_unsigned_q),
    .rd_data_o     (rd_ext)
  );

  // State and clear-pointer registers.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Walk the clear pointer through every word, then hand over to RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(WORDS - 1)) state_d = ST_RUN;
      end
      ST_RUN:  ;
      default: state_d = ST_INIT;
    endcase
  end

  // Array write port: zero fill during INIT, byte-masked stores during RUN.
  // NOTE: the array has no reset branch; its contents are defined by the INIT sweep, which keeps it mappable to block RAM.
  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_INIT) begin
      mem_q[ptr_q] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) mem_q[widx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Synchronous read of the addressed word at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) rd_word_q <= mem_q[widx];
  end

  // Response bookkeeping for the request accepted at this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_load_q    <= 1'b0;
      rd_off_q      <= 2'b00;
      rd_size_q     <= 2'b00;
      rd_unsigned_q <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q     <= req_err;
        rsp_load_q    <= !req_we;
        rd_off_q      <= req_addr[1:0];
        rd_size_q     <= req_size;
        rd_unsigned_q <= req_unsigned;
      end
    end
  end

  assign rsp_valid = rsp_valid_q && !reset;
  assign rsp_err   = rsp_valid && rsp_err_q;
  assign rsp_rdata = (rsp_valid && rsp_load_q && !rsp_err_q) ? rd_ext : 32'h0;

  // Tap bus: a direct view of the tap window of the array.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_taps
    assign taps[32*k +: 32] = mem_q[TAP_WORD0 + k];
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed cases plus random traffic
// compared against a byte-array reference model.
module tb_data_mem_ctrl;

  localparam int DEPTH    = 256;
  localparam int NUM_TAPS = 9;
  localparam int TAP_BASE = 0;
  localparam int TW       = 32 * NUM_TAPS;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          init_busy;
  logic [TW-1:0] taps;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem_m [DEPTH];
  logic [31:0] last_rdata;
  logic        last_err;

  data_mem_ctrl #(
    .DEPTH_BYTES (DEPTH),
    .NUM_TAPS    (NUM_TAPS),
    .TAP_BASE    (TAP_BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .init_busy    (init_busy),
    .taps         (taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic model_err(input logic [1:0] s, input logic [31:0] a);
    int n = nbytes(s);
    if (n == 0) return 1'b1;
    if ((a % n) != 0) return 1'b1;
    if (longint'(a) + n > DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] s, input logic u, input logic [31:0] a);
    int n = nbytes(s);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mem_m[a + i]) << (8 * i));
    if (n == 1 && !u && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !u && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
    int n = nbytes(s);
    for (int i = 0; i < n; i++) mem_m[a + i] = 8'((w >> (8 * i)) & 32'hFF);
  endtask

  function automatic logic [TW-1:0] model_taps();
    logic [TW-1:0] t = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      for (int i = 0; i < 4; i++)
        t[32*k + 8*i +: 8] = mem_m[TAP_BASE + 4*k + i];
    return t;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
  endtask

  // ---------------- stimulus helpers ----------------
  // Present one request (or idle) for a cycle and check its response after the edge.
  task automatic do_cycle(input logic v, input logic we, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
    logic        e;
    logic [31:0] exp_rd;
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    e      = model_err(sz, a);
    exp_rd = (!we && !e) ? model_load(sz, u, a) : 32'h0;
    @(posedge clk);
    #1;
    check({tag, " vld"}, 512'(rsp_valid), 512'(v));
    if (v) begin
      check({tag, " err"},   512'(rsp_err),   512'(e));
      check({tag, " rdata"}, 512'(rsp_rdata), 512'(exp_rd));
      if (we && !e) model_store(sz, a, wd);
    end
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    check({tag, " taps"}, 512'(taps), 512'(model_taps()));
    req_valid = 1'b0;
  endtask

  // Count cycles with init_busy high (bounded); note any response seen meanwhile.
  task automatic wait_init(output int cnt, output logic saw_rsp);
    cnt     = 0;
    saw_rsp = 1'b0;
    while (init_busy && cnt < 200) begin
      if (rsp_valid) saw_rsp = 1'b1;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   cnt;
    logic saw;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    model_clear();

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst rsp_valid", 512'(rsp_valid), 512'(1'b0));
    check("rst rsp_rdata", 512'(rsp_rdata), 512'(32'h0));
    check("rst rsp_err",   512'(rsp_err),   512'(1'b0));
    check("rst init_busy", 512'(init_busy), 512'(1'b1));
    check("rst req_ready", 512'(req_ready), 512'(1'b0));

    // Clear sequence length and post-init state.
    reset = 1'b0;
    wait_init(cnt, saw);
    check("init cycles", 512'(cnt), 512'(64));
    check("init ready",  512'(req_ready), 512'(1'b1));
    check("init taps",   512'(taps), 512'(model_taps()));

    // Byte store into the tap window.
    do_cycle(1, 1, 2'd0, 0, 32'h05, 32'h0000_00AB, "sb05");
    check("sb05 tap1", 512'(taps[63:32]), 512'(32'h0000_AB00));

    // Sign/zero extension.
    do_cycle(1, 1, 2'd2, 0, 32'h3C, 32'h8000_00FF, "sw3c");
    do_cycle(1, 0, 2'd0, 0, 32'h3C, 32'h0, "lb3c");
    check("lb3c const", 512'(last_rdata), 512'(32'hFFFF_FFFF));
    do_cycle(1, 0, 2'd0, 1, 32'h3C, 32'h0, "lbu3c");
    check("lbu3c const", 512'(last_rdata), 512'(32'h0000_00FF));
    do_cycle(1, 0, 2'd1, 0, 32'h3E, 32'h0, "lh3e");
    check("lh3e const", 512'(last_rdata), 512'(32'hFFFF_8000));

    // Error cases: misaligned, out of range, illegal size.
    do_cycle(1, 0, 2'd2, 0, 32'h02,  32'h0, "lw02");
    check("lw02 err const", 512'(last_err), 512'(1'b1));
    do_cycle(1, 1, 2'd1, 0, 32'h03,  32'hDEAD_BEEF, "sh03");
    check("sh03 err const", 512'(last_err), 512'(1'b1));
    do_cycle(1, 0, 2'd2, 0, 32'h100, 32'h0, "lw100");
    check("lw100 err const", 512'(last_err), 512'(1'b1));
    do_cycle(1, 1, 2'd3, 0, 32'h10,  32'hFFFF_FFFF, "sz3");
    check("sz3 err const", 512'(last_err), 512'(1'b1));
    do_cycle(1, 0, 2'd2, 0, 32'hFC,  32'h0, "lwfc");

    // Store followed immediately by a load of the same word.
    do_cycle(1, 1, 2'd2, 0, 32'h40, 32'h1234_5678, "b2b sw");
    do_cycle(1, 0, 2'd2, 0, 32'h40, 32'h0, "b2b lw");
    check("b2b const", 512'(last_rdata), 512'(32'h1234_5678));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        v, we, u;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      v  = ($urandom_range(0, 3) != 0);
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 47));
      else if (r < 8) a = 32'($urandom_range(0, 255));
      else            a = 32'($urandom_range(240, 271));
      do_cycle(v, we, sz, u, a, $urandom, "rnd");
    end

    // Reset in RUN: the clear sequence runs again and wipes the array.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init(cnt, saw);
    model_clear();
    check("run rst cycles", 512'(cnt), 512'(64));
    check("run rst taps",   512'(taps), 512'(model_taps()));

    // Reset at cycle 30 of INIT, with a request held throughout.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) saw = 1'b1;
      @(posedge clk);
      #1;
    end
    check("mid init busy", 512'(init_busy), 512'(1'b1));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    begin
      logic saw2;
      wait_init(cnt, saw2);
      req_valid = 1'b0;
      saw = saw | saw2;
    end
    check("mid init cycles", 512'(cnt), 512'(64));
    check("mid init no rsp", 512'(saw), 512'(1'b0));
    check("mid init taps",   512'(taps), 512'(model_taps()));
    do_cycle(1, 0, 2'd2, 0, 32'h0, 32'h0, "post lw0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
